sva_eval_arbiter: RTL and testbench

- Schedules assertion-thread evaluations from NUM_REQ independent SVA checker instances onto one shared next-state evaluation engine.
- Selects requesters round-robin and runs a single-outstanding handshake with the engine.
- Routes each result back to the owning requester with a success/fail/timeout status.
- Sits between the per-property thread pools and the shared evaluator, in the user clock domain.

---
 rtl/sva_arb_pkg.sv | 42 ++++
 rtl/sva_rr_arbiter.sv | 36 +++
 rtl/sva_eval_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sva_eval_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sva_arb_pkg.sv
// Shared types for the SVA evaluation arbiter: checker FSM ids, response status,
// controller states and the per-thread payload record.
package sva_arb_pkg;

  typedef enum int {
    S0    = 0,
    S1    = 1,
    SEND  = -1,
    SLAZY = -2
  } sva_fsm_t;

  typedef enum logic [1:0] {
    ST_CONT = 2'd0,
    ST_SUCC = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } rsp_status_t;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_ISSUE = 2'd1,
    CTRL_WAIT  = 2'd2,
    CTRL_RESP  = 2'd3
  } ctrl_state_t;

  localparam int STATE_W_DEF = 32;
  localparam int TIMER_W_DEF = 8;
  localparam int CNT_W       = 8;

  typedef struct packed {
    logic [STATE_W_DEF-1:0] state;
    logic [TIMER_W_DEF-1:0] start;
  } sva_thread_t;

  // A result carrying both flags is reported as a failure.
  function automatic rsp_status_t decode_status(input logic succ, input logic fail);
    if (fail)      return ST_FAIL;
    else if (succ) return ST_SUCC;
    else           return ST_CONT;
  endfunction

endpackage

// File: rtl/sva_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module sva_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int               j;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sva_eval_arbiter.sv
// Round-robin scheduler of SVA checker threads onto one shared evaluator.
// Optional statistics counters are enabled by defining SVA_ARB_STATS_EN.
module sva_eval_arbiter
  import sva_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int STATE_W = 32,
  parameter int TIMER_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       gclk,
  input  logic                       grst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*STATE_W-1:0] req_state,
  input  logic [NUM_REQ*TIMER_W-1:0] req_start,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       eval_valid,
  output logic [STATE_W-1:0]         eval_state,
  output logic [TIMER_W-1:0]         eval_start,
  input  logic                       eval_ready,
  input  logic                       res_valid,
  input  logic [STATE_W-1:0]         res_state,
  input  logic                       res_active,
  input  logic                       res_succ,
  input  logic                       res_fail,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [STATE_W-1:0]         rsp_state,
  output logic                       rsp_active,
  output logic [1:0]                 rsp_status,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [15:0]                succ_cnt,
  output logic [15:0]                fail_cnt,
  output logic [15:0]                tmo_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ctrl_state_t        ctrl_q, ctrl_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [STATE_W-1:0] state_q, state_d, rsp_state_q, rsp_state_d;
  logic [TIMER_W-1:0] start_q, start_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_active_q, rsp_active_d, tmo_err_q, tmo_err_d;
  rsp_status_t        rsp_status_q, rsp_status_d;

  logic [STATE_W-1:0] state_arr [NUM_REQ];
  logic [TIMER_W-1:0] start_arr [NUM_REQ];
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign state_arr[gi] = req_state[gi*STATE_W +: STATE_W];
      assign start_arr[gi] = req_start[gi*TIMER_W +: TIMER_W];
      assign rsp_valid[gi] = (ctrl_q == CTRL_RESP) && (owner_q == IDX_W'(gi));
    end
  endgenerate

  sva_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign gnt         = (ctrl_q == CTRL_IDLE) ? arb_gnt : '0;
  assign eval_valid  = (ctrl_q == CTRL_ISSUE);
  assign eval_state  = state_q;
  assign eval_start  = start_q;
  assign rsp_state   = rsp_state_q;
  assign rsp_active  = rsp_active_q;
  assign rsp_status  = rsp_status_q;
  assign busy        = (ctrl_q != CTRL_IDLE);
  assign timeout_err = tmo_err_q;

  always_comb begin
    ctrl_d       = ctrl_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    state_d      = state_q;
    start_d      = start_q;
    cnt_d        = cnt_q;
    rsp_state_d  = rsp_state_q;
    rsp_active_d = rsp_active_q;
    rsp_status_d = rsp_status_q;
    tmo_err_d    = tmo_err_q;
    case (ctrl_q)
      CTRL_IDLE: if (arb_any) begin
        owner_d = arb_idx;
        state_d = state_arr[arb_idx];
        start_d = start_arr[arb_idx];
        ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        ctrl_d  = CTRL_ISSUE;
      end
      CTRL_ISSUE: if (eval_ready) begin
        cnt_d  = '0;
        ctrl_d = CTRL_WAIT;
      end
      CTRL_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A result arriving on the last allowed cycle beats the timeout.
        if (res_valid) begin
          rsp_state_d  = res_state;
          rsp_active_d = res_active;
          rsp_status_d = decode_status(res_succ, res_fail);
          ctrl_d       = CTRL_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_state_d  = '0;
          rsp_active_d = 1'b0;
          rsp_status_d = ST_TMO;
          tmo_err_d    = 1'b1;
          ctrl_d       = CTRL_RESP;
        end
      end
      CTRL_RESP: ctrl_d = CTRL_IDLE;
      default:   ctrl_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      ctrl_q       <= CTRL_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      state_q      <= '0;
      start_q      <= '0;
      cnt_q        <= '0;
      rsp_state_q  <= '0;
      rsp_active_q <= 1'b0;
      rsp_status_q <= ST_CONT;
      tmo_err_q    <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      state_q      <= state_d;
      start_q      <= start_d;
      cnt_q        <= cnt_d;
      rsp_state_q  <= rsp_state_d;
      rsp_active_q <= rsp_active_d;
      rsp_status_q <= rsp_status_d;
      tmo_err_q    <= tmo_err_d;
    end
  end

`ifdef SVA_ARB_STATS_EN
  logic [15:0] succ_cnt_q, fail_cnt_q, tmo_cnt_q;

  // rsp_status_q already holds the status of the response being delivered.
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      succ_cnt_q <= '0;
      fail_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else if (ctrl_q == CTRL_RESP) begin
      if (rsp_status_q == ST_SUCC && succ_cnt_q != 16'hFFFF) succ_cnt_q <= succ_cnt_q + 16'd1;
      if (rsp_status_q == ST_FAIL && fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
      if (rsp_status_q == ST_TMO  && tmo_cnt_q  != 16'hFFFF) tmo_cnt_q  <= tmo_cnt_q  + 16'd1;
    end
  end

  assign succ_cnt = succ_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign tmo_cnt  = tmo_cnt_q;
`else
  assign succ_cnt = '0;
  assign fail_cnt = '0;
  assign tmo_cnt  = '0;
`endif

endmodule

// File: tb/tb_sva_eval_arbiter.sv
// Directed bench for sva_eval_arbiter: grant order, handshake, timeout, race and reset.
module tb_sva_eval_arbiter;
  import sva_arb_pkg::*;

  localparam int N  = 4;
  localparam int SW = 32;
  localparam int TW = 8;

`ifdef SVA_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            gclk, grst;
  logic [N-1:0]    req;
  logic [N*SW-1:0] req_state;
  logic [N*TW-1:0] req_start;
  logic [N-1:0]    gnt;
  logic            eval_valid;
  logic [SW-1:0]   eval_state;
  logic [TW-1:0]   eval_start;
  logic            eval_ready, res_valid, res_active, res_succ, res_fail;
  logic [SW-1:0]   res_state;
  logic [N-1:0]    rsp_valid;
  logic [SW-1:0]   rsp_state;
  logic            rsp_active;
  logic [1:0]      rsp_status;
  logic            busy, timeout_err;
  logic [15:0]     succ_cnt, fail_cnt, tmo_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int last_busy;

  logic [SW-1:0] pl_state [N];
  logic [TW-1:0] pl_start [N];

  sva_eval_arbiter #(.NUM_REQ(N), .STATE_W(SW), .TIMER_W(TW), .TIMEOUT(15)) dut (
    .gclk(gclk), .grst(grst), .req(req), .req_state(req_state), .req_start(req_start),
    .gnt(gnt), .eval_valid(eval_valid), .eval_state(eval_state), .eval_start(eval_start),
    .eval_ready(eval_ready), .res_valid(res_valid), .res_state(res_state),
    .res_active(res_active), .res_succ(res_succ), .res_fail(res_fail),
    .rsp_valid(rsp_valid), .rsp_state(rsp_state), .rsp_active(rsp_active),
    .rsp_status(rsp_status), .busy(busy), .timeout_err(timeout_err),
    .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // One full transaction; res_wait = WAIT cycles without a result before res_valid.
  task automatic run_txn(input string nm, input logic [N-1:0] rq, input int owner, input bit hold,
                         input int res_wait, input logic [SW-1:0] rs, input logic ra,
                         input logic rsucc, input logic rfail, input logic [1:0] exp_st);
    int busy_n;
    busy_n = 0;
    req = rq;
    #1;
    chk({nm, ".gnt"}, 32'(gnt), 32'(1 << owner));
    tick();
    if (!hold) req = '0;
    busy_n += int'(busy);
    chk({nm, ".eval_state"}, eval_state, pl_state[owner]);
    chk({nm, ".eval_start"}, 32'(eval_start), 32'(pl_start[owner]));
    chk({nm, ".gnt_issue"}, 32'(gnt), 32'd0);
    // A stray result during ISSUE must be ignored.
    eval_ready = 1'b1; res_valid = 1'b1; res_state = 32'hDEAD_BEEF; res_active = 1'b1;
    res_succ = 1'b1; res_fail = 1'b0;
    tick();
    eval_ready = 1'b0; res_valid = 1'b0; res_succ = 1'b0;
    busy_n += int'(busy);
    for (int k = 0; k < res_wait; k++) begin
      tick();
      busy_n += int'(busy);
    end
    res_valid = 1'b1; res_state = rs; res_active = ra; res_succ = rsucc; res_fail = rfail;
    tick();
    res_valid = 1'b0; res_succ = 1'b0; res_fail = 1'b0; res_active = 1'b0; res_state = '0;
    busy_n += int'(busy);
    chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'(1 << owner));
    chk({nm, ".rsp_state"}, rsp_state, rs);
    chk({nm, ".rsp_status"}, 32'(rsp_status), 32'(exp_st));
    chk({nm, ".rsp_active"}, 32'(rsp_active), 32'(ra));
    tick();
    chk({nm, ".rsp_1cyc"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".rsp_hold"}, 32'(rsp_status), 32'(exp_st));
    last_busy = busy_n + int'(busy);
  endtask

  initial begin
    int lat;
    pl_state[0] = 32'(S1);    pl_state[1] = 32'(S0);
    pl_state[2] = 32'(SEND);  pl_state[3] = 32'(SLAZY);
    for (int i = 0; i < N; i++) pl_start[i] = TW'(8'hA0 + i);
    for (int i = 0; i < N; i++) begin
      req_state[i*SW +: SW] = pl_state[i];
      req_start[i*TW +: TW] = pl_start[i];
    end
    grst = 1'b1; req = '0; eval_ready = 1'b0; res_valid = 1'b0;
    res_state = '0; res_active = 1'b0; res_succ = 1'b0; res_fail = 1'b0;
    repeat (3) @(posedge gclk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.eval_valid", 32'(eval_valid), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.timeout_err", 32'(timeout_err), 32'd0);
    chk("rst.rsp_status", 32'(rsp_status), 32'd0);
    grst = 1'b0;
    tick();
    chk("idle.gnt_noreq", 32'(gnt), 32'd0);

    // Single request, result S1 active, continue status; 4 busy cycles.
    run_txn("single", 4'b0010, 1, 1'b0, 1, 32'(S1), 1'b1, 1'b0, 1'b0, 2'd0);
    chk("single.busy_cycles", 32'(last_busy), 32'd4);

    // Timeout: pointer now 2, only requester 0 asks.
    req = 4'b0001;
    #1;
    chk("tmo.gnt", 32'(gnt), 32'b0001);
    tick();
    req = '0;
    eval_ready = 1'b1;
    tick();
    eval_ready = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (rsp_valid != '0) begin
        lat = k;
        break;
      end
    end
    chk("tmo.latency", 32'(lat), 32'd15);
    chk("tmo.rsp_valid", 32'(rsp_valid), 32'b0001);
    chk("tmo.rsp_status", 32'(rsp_status), 32'd3);
    chk("tmo.rsp_state", rsp_state, 32'd0);
    chk("tmo.rsp_active", 32'(rsp_active), 32'd0);
    tick();
    tick();
    chk("tmo.err_sticky", 32'(timeout_err), 32'd1);
    chk("tmo.cnt", 32'(tmo_cnt), STATS ? 32'd1 : 32'd0);

    // Reset in the middle of WAIT aborts without a response.
    req = 4'b0100;
    #1;
    chk("rstwait.gnt", 32'(gnt), 32'b0100);
    tick();
    req = '0;
    eval_ready = 1'b1;
    tick();
    eval_ready = 1'b0;
    tick(); tick();
    grst = 1'b1;
    #2;
    chk("rstwait.busy", 32'(busy), 32'd0);
    chk("rstwait.timeout_err", 32'(timeout_err), 32'd0);
    chk("rstwait.tmo_cnt", 32'(tmo_cnt), 32'd0);
    grst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstwait.no_rsp", 32'(rsp_valid), 32'd0);
    end

    // Fairness with all requesters held: order 0,1,2,3,0,1,2,3.
    run_txn("fair0", 4'b1111, 0, 1'b1, 0, 32'h11, 1'b0, 1'b1, 1'b0, 2'd1);
    run_txn("fair1", 4'b1111, 1, 1'b1, 0, 32'h12, 1'b0, 1'b1, 1'b0, 2'd1);
    run_txn("fair2", 4'b1111, 2, 1'b1, 0, 32'h13, 1'b0, 1'b0, 1'b1, 2'd2);
    run_txn("fair3", 4'b1111, 3, 1'b1, 0, 32'h14, 1'b0, 1'b1, 1'b0, 2'd1);
    chk("stats.succ", 32'(succ_cnt), STATS ? 32'd3 : 32'd0);
    chk("stats.fail", 32'(fail_cnt), STATS ? 32'd1 : 32'd0);
    run_txn("fair4", 4'b1111, 0, 1'b1, 0, 32'h21, 1'b1, 1'b0, 1'b0, 2'd0);
    run_txn("fair5", 4'b1111, 1, 1'b1, 2, 32'h22, 1'b1, 1'b0, 1'b0, 2'd0);
    run_txn("fair6", 4'b1111, 2, 1'b1, 0, 32'h23, 1'b1, 1'b0, 1'b0, 2'd0);
    run_txn("fair7", 4'b1111, 3, 1'b0, 0, 32'h24, 1'b1, 1'b0, 1'b0, 2'd0);

    // Pointer honoured and wrapped around requester 3.
    run_txn("ptr2", 4'b0100, 2, 1'b0, 0, 32'h31, 1'b1, 1'b0, 1'b0, 2'd0);
    run_txn("ptr3", 4'b1001, 3, 1'b0, 0, 32'h32, 1'b1, 1'b0, 1'b0, 2'd0);
    run_txn("wrap", 4'b1001, 0, 1'b0, 0, 32'h33, 1'b1, 1'b0, 1'b0, 2'd0);

    // Result on the final WAIT cycle beats the timeout.
    run_txn("race", 4'b0010, 1, 1'b0, 14, 32'h41, 1'b0, 1'b1, 1'b0, 2'd1);
    chk("race.timeout_err", 32'(timeout_err), 32'd0);

    // Both flags set reports fail.
    run_txn("both", 4'b0100, 2, 1'b0, 0, 32'h51, 1'b0, 1'b1, 1'b1, 2'd2);
    chk("both.stats_succ", 32'(succ_cnt), STATS ? 32'd4 : 32'd0);
    chk("both.stats_fail", 32'(fail_cnt), STATS ? 32'd2 : 32'd0);

    grst = 1'b1;
    #2;
    chk("final_rst.succ", 32'(succ_cnt), 32'd0);
    chk("final_rst.fail", 32'(fail_cnt), 32'd0);
    chk("final_rst.status", 32'(rsp_status), 32'd0);
    grst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
